// File: rtl/cell_line_buffer_pkg.sv
// Shared geometry constants and fill-FSM state encoding for cell_line_buffer.
package cell_line_buffer_pkg;
    localparam int unsigned CELLS_PER_ROW = 80;
    localparam int unsigned CELL_SHIFT    = 3;
    localparam int unsigned WORD_W        = 16;
    localparam int unsigned LINES         = 480;
    localparam int unsigned ADDR_W        = 9;
    localparam int unsigned ROW_W         = 9;
    localparam int unsigned COL_W         = 10;
    localparam int unsigned WORDS_PER_ROW = CELLS_PER_ROW / WORD_W;
    localparam int unsigned WIDX_W        = $clog2(WORDS_PER_ROW);
    localparam int unsigned CIDX_W        = COL_W - CELL_SHIFT;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE
    } fill_state_e;
endpackage

// File: rtl/cell_line_bank.sv
// One-line cell bitmap: word-wide write port, single-bit read port, cleared on reset.
module cell_line_bank
    import cell_line_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [WIDX_W-1:0] wr_idx,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [CIDX_W-1:0] rd_idx,
    output logic              rd_bit
);
    logic [CELLS_PER_ROW-1:0] bits_q, bits_d;

    always_comb begin
        bits_d = bits_q;
        for (int unsigned w = 0; w < WORDS_PER_ROW; w++) begin
            if (wr_en && (wr_idx == WIDX_W'(w))) begin
                bits_d[w*WORD_W +: WORD_W] = wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bits_q <= '0;
        end else begin
            bits_q <= bits_d;
        end
    end

    always_comb begin
        rd_bit = 1'b0;
        if (rd_idx < CIDX_W'(CELLS_PER_ROW)) begin
            rd_bit = bits_q[rd_idx];
        end
    end
endmodule

// File: rtl/cell_line_buffer.sv
// Ping-pong cell line buffer: fetches the next line's cell row while the current one is shown.
// Optional CELL_LINE_GRID_EN overlays the cell grid on cellAlive.
module cell_line_buffer
    import cell_line_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              pixEn,
    input  logic [ROW_W-1:0]  row,
    input  logic [COL_W-1:0]  column,
    input  logic              displayActive,
    output logic              memReq,
    output logic [ADDR_W-1:0] memAddr,
    input  logic              memAck,
    input  logic [WORD_W-1:0] memData,
    output logic              cellAlive,
    output logic              underrun
);
    fill_state_e       state_q, state_d;
    logic [WIDX_W-1:0] word_idx_q, word_idx_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_req_q, mem_req_d;
    logic              fill_done_q, fill_done_d;
    logic              bank_sel_q, bank_sel_d;
    logic              blank_q, blank_d;
    logic              underrun_q, underrun_d;
    logic              cell_alive_q, cell_alive_d;

    logic              line_start;
    logic [ROW_W-1:0]  next_line;
    logic [ADDR_W-1:0] row_base;
    logic [CIDX_W-1:0] cell_idx;
    logic              word_wr;
    logic [1:0]        bank_wr;
    logic [1:0]        bank_rd;

    always_comb begin
        line_start = pixEn && (column == '0);
        next_line  = (row == ROW_W'(LINES - 1)) ? '0 : row + 1'b1;
        row_base   = ADDR_W'(next_line >> CELL_SHIFT) * ADDR_W'(WORDS_PER_ROW);
        cell_idx   = column[COL_W-1:CELL_SHIFT];
        word_wr    = (state_q == FETCH) && memAck && !line_start;
        bank_wr[0] = word_wr && bank_sel_q;
        bank_wr[1] = word_wr && !bank_sel_q;

        state_d     = state_q;
        word_idx_d  = word_idx_q;
        mem_addr_d  = mem_addr_q;
        mem_req_d   = mem_req_q;
        fill_done_d = fill_done_q;
        bank_sel_d  = bank_sel_q;
        blank_d     = blank_q;
        underrun_d  = underrun_q;

        if (line_start) begin
            if (fill_done_q) begin
                bank_sel_d = !bank_sel_q;
                blank_d    = 1'b0;
            end else begin
                blank_d = 1'b1;
                // Late only if a fill was actually requested and the line starting is visible.
                if ((state_q != IDLE) && (row < ROW_W'(LINES))) begin
                    underrun_d = 1'b1;
                end
            end
            state_d     = FETCH;
            word_idx_d  = '0;
            mem_addr_d  = row_base;
            mem_req_d   = 1'b1;
            fill_done_d = 1'b0;
        end else if ((state_q == FETCH) && memAck) begin
            if (word_idx_q == WIDX_W'(WORDS_PER_ROW - 1)) begin
                state_d     = DONE;
                mem_req_d   = 1'b0;
                fill_done_d = 1'b1;
            end else begin
                word_idx_d = word_idx_q + 1'b1;
                mem_addr_d = mem_addr_q + 1'b1;
            end
        end
    end

    // Reads use next-state bank/blank so the line-start pixel already sees the new line.
    always_comb begin
        cell_alive_d = cell_alive_q;
        if (pixEn) begin
            cell_alive_d = displayActive && !blank_d &&
                           (bank_sel_d ? bank_rd[1] : bank_rd[0]);
`ifdef CELL_LINE_GRID_EN
            if (displayActive && ((column[CELL_SHIFT-1:0] == '0) ||
                                  (row[CELL_SHIFT-1:0] == '0))) begin
                cell_alive_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            word_idx_q   <= '0;
            mem_addr_q   <= '0;
            mem_req_q    <= 1'b0;
            fill_done_q  <= 1'b0;
            bank_sel_q   <= 1'b0;
            blank_q      <= 1'b0;
            underrun_q   <= 1'b0;
            cell_alive_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_idx_q   <= word_idx_d;
            mem_addr_q   <= mem_addr_d;
            mem_req_q    <= mem_req_d;
            fill_done_q  <= fill_done_d;
            bank_sel_q   <= bank_sel_d;
            blank_q      <= blank_d;
            underrun_q   <= underrun_d;
            cell_alive_q <= cell_alive_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        cell_line_bank u_bank (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (bank_wr[b]),
            .wr_idx  (word_idx_q),
            .wr_data (memData),
            .rd_idx  (cell_idx),
            .rd_bit  (bank_rd[b])
        );
    end

    assign memReq    = mem_req_q;
    assign memAddr   = mem_addr_q;
    assign cellAlive = cell_alive_q;
    assign underrun  = underrun_q;
endmodule

// File: tb/tb_cell_line_buffer.sv
// Scoreboard bench for cell_line_buffer: scans whole lines against a memory model.
module tb_cell_line_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pixEn = 1'b0;
    logic [8:0]  row = '0;
    logic [9:0]  column = '0;
    logic        displayActive = 1'b0;
    logic        memReq;
    logic [8:0]  memAddr;
    logic        memAck = 1'b0;
    logic [15:0] memData = '0;
    logic        cellAlive;
    logic        underrun;

    always #5 clk = ~clk;

    cell_line_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .pixEn         (pixEn),
        .row           (row),
        .column        (column),
        .displayActive (displayActive),
        .memReq        (memReq),
        .memAddr       (memAddr),
        .memAck        (memAck),
        .memData       (memData),
        .cellAlive     (cellAlive),
        .underrun      (underrun)
    );

    logic [15:0] mem_words [512];
    bit          mem_en = 1'b0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    bit          man_ack = 1'b0;
    logic [15:0] man_data = '0;
    int          ack_addrs[$];
    bit          sb[$];
    int          n_tests = 0;
    int          n_fail = 0;
    bit          prev_req = 1'b0;
    logic [8:0]  prev_addr = '0;
    int          addr_jumps = 0;

    // Memory responder: auto mode acks after ack_delay cycles, manual mode follows man_ack.
    always @(negedge clk) begin
        if (memReq && prev_req && !memAck && (memAddr !== prev_addr)) addr_jumps++;
        prev_req  = memReq;
        prev_addr = memAddr;
        if (mem_en) begin
            memAck = 1'b0;
            if (memReq && !rst) begin
                if (wait_cnt >= ack_delay) begin
                    memAck  = 1'b1;
                    memData = mem_words[memAddr];
                    ack_addrs.push_back(int'(memAddr));
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end else begin
            memAck   = man_ack;
            memData  = man_data;
            wait_cnt = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit exp_alive(input int r, input int c, input bit da, input bit blank);
        bit          b;
        int          cr;
        int          ci;
        logic [15:0] w;
        b = 1'b0;
        if (da && !blank) begin
            cr = r >> 3;
            ci = c >> 3;
            w  = mem_words[cr * 5 + ci / 16];
            b  = w[ci % 16];
        end
`ifdef CELL_LINE_GRID_EN
        if (da && (((c % 8) == 0) || ((r % 8) == 0))) b = 1'b1;
`endif
        return b;
    endfunction

    task automatic pix(input int r, input int c, input bit blank);
        bit da;
        bit e;
        da = (r < 480) && (c < 640);
        @(negedge clk);
        pixEn         = 1'b1;
        row           = 9'(r);
        column        = 10'(c);
        displayActive = da;
        sb.push_back(exp_alive(r, c, da, blank));
        @(posedge clk);
        #1;
        pixEn = 1'b0;
        e = sb.pop_front();
        n_tests++;
        if (cellAlive !== e) begin
            n_fail++;
            $display("FAIL cellAlive r=%0d c=%0d: got %b expected %b", r, c, cellAlive, e);
        end
    endtask

    task automatic scan_line(input int r, input int c0, input bit blank);
        for (int c = c0; c < 800; c++) pix(r, c, blank);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        pixEn   = 1'b0;
        man_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        ack_addrs.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests += 4;
        if (memReq !== 1'b0) begin n_fail++; $display("FAIL reset_memReq: got %b expected 0", memReq); end
        if (memAddr !== 9'd0) begin n_fail++; $display("FAIL reset_memAddr: got %0d expected 0", memAddr); end
        if (cellAlive !== 1'b0) begin n_fail++; $display("FAIL reset_cellAlive: got %b expected 0", cellAlive); end
        if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
    endtask

    task automatic test_basic_fill();
        do_reset();
        mem_words[5] = 16'h0001;
        mem_words[6] = 16'h0000;
        mem_words[7] = 16'h0000;
        mem_words[8] = 16'h0000;
        mem_words[9] = 16'h8000;
        mem_en = 1'b1; ack_delay = 0;
        scan_line(7, 0, 1'b1);
        n_tests++;
        if (ack_addrs.size() != 5) begin
            n_fail++; $display("FAIL basic_ack_count: got %0d expected 5", ack_addrs.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_tests++;
                if (ack_addrs[i] != 5 + i) begin
                    n_fail++; $display("FAIL basic_addr[%0d]: got %0d expected %0d", i, ack_addrs[i], 5 + i);
                end
            end
        end
        n_tests++;
        if (memReq !== 1'b0) begin n_fail++; $display("FAIL basic_req_done: got %b expected 0", memReq); end
        scan_line(8, 0, 1'b0);
    endtask

    task automatic test_ack_latency();
        do_reset();
        mem_en = 1'b1; ack_delay = 3;
        addr_jumps = 0;
        scan_line(7, 0, 1'b1);
        n_tests += 3;
        if (addr_jumps != 0) begin n_fail++; $display("FAIL latency_addr_stable: got %0d changes expected 0", addr_jumps); end
        if (ack_addrs.size() != 5) begin n_fail++; $display("FAIL latency_ack_count: got %0d expected 5", ack_addrs.size()); end
        if (memReq !== 1'b0) begin n_fail++; $display("FAIL latency_fill_done: memReq got %b expected 0", memReq); end
        scan_line(8, 0, 1'b0);
        n_tests++;
        if (underrun !== 1'b0) begin n_fail++; $display("FAIL latency_underrun: got %b expected 0", underrun); end
        ack_delay = 0;
    endtask

    task automatic test_underrun();
        do_reset();
        mem_en = 1'b1; ack_delay = 0;
        scan_line(45, 0, 1'b1);
        @(posedge clk); #1;
        mem_en = 1'b0;
        scan_line(46, 0, 1'b0);
        n_tests++;
        if (underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_before: got %b expected 0", underrun); end
        pix(47, 0, 1'b1);
        n_tests += 3;
        if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_flag: got %b expected 1", underrun); end
        if (memReq !== 1'b1) begin n_fail++; $display("FAIL underrun_req: got %b expected 1", memReq); end
        if (memAddr !== 9'd30) begin n_fail++; $display("FAIL underrun_restart_addr: got %0d expected 30", memAddr); end
        scan_line(47, 1, 1'b1);
    endtask

    task automatic test_collision();
        do_reset();
        mem_en = 1'b0;
        pix(22, 0, 1'b1);
        man_data = 16'h1234; man_ack = 1'b1;
        @(posedge clk); #1;
        man_ack = 1'b0;
        n_tests++;
        if (memAddr !== 9'd11) begin n_fail++; $display("FAIL collision_pre_addr: got %0d expected 11", memAddr); end
        man_data = 16'hFFFF; man_ack = 1'b1;
        pix(23, 0, 1'b1);
        man_ack = 1'b0;
        n_tests += 3;
        if (memAddr !== 9'd15) begin n_fail++; $display("FAIL collision_addr: got %0d expected 15", memAddr); end
        if (memReq !== 1'b1) begin n_fail++; $display("FAIL collision_req: got %b expected 1", memReq); end
        if (underrun !== 1'b1) begin n_fail++; $display("FAIL collision_underrun: got %b expected 1", underrun); end
        ack_addrs.delete();
        mem_en = 1'b1;
        scan_line(23, 1, 1'b1);
        n_tests++;
        if (ack_addrs.size() != 5) begin
            n_fail++; $display("FAIL collision_ack_count: got %0d expected 5", ack_addrs.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_tests++;
                if (ack_addrs[i] != 15 + i) begin
                    n_fail++; $display("FAIL collision_addr[%0d]: got %0d expected %0d", i, ack_addrs[i], 15 + i);
                end
            end
        end
        scan_line(24, 0, 1'b0);
    endtask

    task automatic test_wrap();
        do_reset();
        mem_en = 1'b1; ack_delay = 0;
        scan_line(478, 0, 1'b1);
        ack_addrs.delete();
        scan_line(479, 0, 1'b0);
        n_tests++;
        if (ack_addrs.size() != 5) begin
            n_fail++; $display("FAIL wrap_ack_count: got %0d expected 5", ack_addrs.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_tests++;
                if (ack_addrs[i] != i) begin
                    n_fail++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", i, ack_addrs[i], i);
                end
            end
        end
        scan_line(0, 0, 1'b0);
        scan_line(520, 0, 1'b0);
        n_tests++;
        if (underrun !== 1'b0) begin n_fail++; $display("FAIL wrap_underrun: got %b expected 0", underrun); end
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        mem_en = 1'b0;
        pix(7, 0, 1'b1);
        man_data = 16'hFFFF; man_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        man_ack = 1'b0;
        n_tests++;
        if (memAddr !== 9'd7) begin n_fail++; $display("FAIL midreset_pre_addr: got %0d expected 7", memAddr); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_tests += 4;
        if (memReq !== 1'b0) begin n_fail++; $display("FAIL midreset_memReq: got %b expected 0", memReq); end
        if (memAddr !== 9'd0) begin n_fail++; $display("FAIL midreset_memAddr: got %0d expected 0", memAddr); end
        if (cellAlive !== 1'b0) begin n_fail++; $display("FAIL midreset_cellAlive: got %b expected 0", cellAlive); end
        if (underrun !== 1'b0) begin n_fail++; $display("FAIL midreset_underrun: got %b expected 0", underrun); end
        rst = 1'b0;
        mem_en = 1'b1; ack_delay = 0;
        scan_line(8, 0, 1'b1);
        n_tests++;
        if (underrun !== 1'b0) begin n_fail++; $display("FAIL midreset_underrun_after: got %b expected 0", underrun); end
        scan_line(9, 0, 1'b0);
    endtask

`ifdef CELL_LINE_GRID_EN
    task automatic test_grid();
        do_reset();
        mem_en = 1'b0;
        scan_line(16, 0, 1'b1);
        scan_line(17, 0, 1'b1);
    endtask
`endif

    initial begin
        for (int a = 0; a < 512; a++) mem_words[a] = 16'(a * 40503 + 7);
        test_reset();
        test_basic_fill();
        test_ack_latency();
        test_underrun();
        test_collision();
        test_wrap();
        test_reset_mid_fetch();
`ifdef CELL_LINE_GRID_EN
        test_grid();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
